// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: FSM state encoding, maze dimension,
// movement direction codes and the button-priority helper.
package maze_pkg;

  localparam int MAZE_DIM = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLACE    = 3'd1,
    PLAY     = 3'd2,
    CHECK    = 3'd3,
    COOLDOWN = 3'd4,
    WIN      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Simultaneous presses resolve as up > down > left > right.
  function automatic dir_e pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    dir_e d;
    if (up) begin
      d = DIR_UP;
    end else if (down) begin
      d = DIR_DOWN;
    end else if (left) begin
      d = DIR_LEFT;
    end else if (right) begin
      d = DIR_RIGHT;
    end else begin
      d = DIR_UP;
    end
    return d;
  endfunction

endpackage

// File: rtl/maze_move_controller_timer.sv
// Post-move cooldown counter: load arms it with MOVE_DELAY, count steps it
// down, done pulses in the final counted cycle.
module move_timer #(
  parameter int MOVE_DELAY = 4_000_000,
  parameter int WIDTH      = (MOVE_DELAY < 1) ? 1 : $clog2(MOVE_DELAY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [WIDTH-1:0] cnt_r;

  assign done = count && (cnt_r <= WIDTH'(1));

  // Countdown register with clear taking priority over load and count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= WIDTH'(MOVE_DELAY);
    end else if (count && (cnt_r != '0)) begin
      cnt_r <= cnt_r - WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/maze_move_controller.sv
// Maze character movement FSM with cooldown auto-repeat and win detection.
// Optional accepted-move counter port enabled by `define MAZE_MOVE_COUNT_EN.
module maze_move_controller
  import maze_pkg::*;
#(
  parameter int MOVE_DELAY = 4_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic [255:0] path_data,
  input  logic [4:0]   maze_width,
  input  logic [4:0]   maze_height,
  input  logic [4:0]   start_x,
  input  logic [4:0]   start_y,
  input  logic [4:0]   finish_x,
  input  logic [4:0]   finish_y,
  output logic [6:0]   char_x,
  output logic [6:0]   char_y,
  output logic         render_enable,
`ifdef MAZE_MOVE_COUNT_EN
  output logic         win,
  output logic [15:0]  move_count
`else
  output logic         win
`endif
);

  state_e     state_r;
  dir_e       dir_r;
  logic [6:0] char_x_r;
  logic [6:0] char_y_r;
  logic       render_r;
  logic       win_r;

  logic [6:0] tx_s;
  logic [6:0] ty_s;
  logic       in_bounds_s;
  logic [7:0] idx_s;
  logic       open_s;
  logic       hit_finish_s;
  logic       any_btn_s;
  logic       timer_load_s;
  logic       timer_count_s;
  logic       timer_done_s;

  assign any_btn_s = btn_up | btn_down | btn_left | btn_right;

  // Target tile for the latched direction; bounds gate the map lookup index.
  always_comb begin
    tx_s         = char_x_r;
    ty_s         = char_y_r;
    in_bounds_s  = 1'b0;
    idx_s        = 8'd0;
    open_s       = 1'b0;
    hit_finish_s = 1'b0;
    case (dir_r)
      DIR_UP: begin
        ty_s        = char_y_r - 7'd1;
        in_bounds_s = (char_y_r != 7'd0);
      end
      DIR_DOWN: begin
        ty_s        = char_y_r + 7'd1;
        in_bounds_s = ((char_y_r + 7'd1) < {2'b00, maze_height});
      end
      DIR_LEFT: begin
        tx_s        = char_x_r - 7'd1;
        in_bounds_s = (char_x_r != 7'd0);
      end
      DIR_RIGHT: begin
        tx_s        = char_x_r + 7'd1;
        in_bounds_s = ((char_x_r + 7'd1) < {2'b00, maze_width});
      end
      default: begin
        in_bounds_s = 1'b0;
      end
    endcase
    // A width/height above MAZE_DIM must still never address past the map.
    if (in_bounds_s && (tx_s < 7'(MAZE_DIM)) && (ty_s < 7'(MAZE_DIM))) begin
      idx_s  = {ty_s[3:0], tx_s[3:0]};
      open_s = path_data[idx_s];
    end else begin
      idx_s  = 8'd0;
      open_s = 1'b0;
    end
    hit_finish_s = (tx_s == {2'b00, finish_x}) && (ty_s == {2'b00, finish_y});
  end

  assign timer_load_s  = (state_r == CHECK) && open_s && !hit_finish_s;
  assign timer_count_s = (state_r == COOLDOWN);

  move_timer #(
    .MOVE_DELAY(MOVE_DELAY)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(start),
    .load (timer_load_s),
    .count(timer_count_s),
    .done (timer_done_s)
  );

  // Game FSM with registered position, renderer enable and win flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      dir_r    <= DIR_UP;
      char_x_r <= 7'd0;
      char_y_r <= 7'd0;
      render_r <= 1'b0;
      win_r    <= 1'b0;
    end else if (start) begin
      state_r  <= PLACE;
      render_r <= 1'b1;
      win_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        PLACE: begin
          char_x_r <= {2'b00, start_x};
          char_y_r <= {2'b00, start_y};
          state_r  <= PLAY;
        end
        PLAY: begin
          if (any_btn_s) begin
            dir_r   <= pick_dir(btn_up, btn_down, btn_left, btn_right);
            state_r <= CHECK;
          end else begin
            state_r <= PLAY;
          end
        end
        CHECK: begin
          if (open_s) begin
            char_x_r <= tx_s;
            char_y_r <= ty_s;
            if (hit_finish_s) begin
              state_r <= WIN;
              win_r   <= 1'b1;
            end else begin
              state_r <= COOLDOWN;
            end
          end else begin
            state_r <= PLAY;
          end
        end
        COOLDOWN: begin
          if (timer_done_s) begin
            state_r <= PLAY;
          end else begin
            state_r <= COOLDOWN;
          end
        end
        WIN: begin
          state_r <= WIN;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign char_x        = char_x_r;
  assign char_y        = char_y_r;
  assign render_enable = render_r;
  assign win           = win_r;

`ifdef MAZE_MOVE_COUNT_EN
  logic [15:0] move_count_r;

  // Accepted-move counter, saturating, cleared by a new game.
  always_ff @(posedge clk) begin
    if (!reset) begin
      move_count_r <= 16'd0;
    end else if (start) begin
      move_count_r <= 16'd0;
    end else if ((state_r == CHECK) && open_s && (move_count_r != 16'hFFFF)) begin
      move_count_r <= move_count_r + 16'd1;
    end else begin
      move_count_r <= move_count_r;
    end
  end

  assign move_count = move_count_r;
`endif

endmodule
